// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-ported memory between instruction fetch and
// load/store traffic. Data accesses win over fetches, only one transaction
// is ever outstanding, and a wait counter turns a missing response into a
// bus error so the pipeline can never hang on the memory.
module mem_port_arbiter #(
    parameter int unsigned TO_CYCLES = 255
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        if_req_i,
    input  logic [31:0] if_addr_i,
    output logic [31:0] if_rdata_o,
    output logic        if_valid_o,
    input  logic        dm_req_i,
    input  logic        dm_we_i,
    input  logic [3:0]  dm_be_i,
    input  logic [31:0] dm_addr_i,
    input  logic [31:0] dm_wdata_i,
    output logic [31:0] dm_rdata_o,
    output logic        dm_valid_o,
    input  logic        flush_i,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_gnt_i,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i,
    output logic        stall_fd_o,
    output logic        stall_mw_o,
    output logic        bus_err_o
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_DWAIT = 2'd1;
    localparam logic [1:0] S_IWAIT = 2'd2;
    localparam logic [1:0] S_IDROP = 2'd3;

    // Counter value on the last wait cycle that is still allowed to complete.
    localparam logic [7:0] TO_LAST = 8'(TO_CYCLES - 1);

    logic [1:0] state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic       timeout;
    logic       req;

    assign timeout = (cnt_q == TO_LAST);

    // Next-state, request muxing, completion pulses and stalls.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        state_d     = state_q;
        cnt_d       = cnt_q;
        req         = 1'b0;
        mem_req_o   = 1'b0;
        if_valid_o  = 1'b0;
        if_rdata_o  = '0;
        dm_valid_o  = 1'b0;
        dm_rdata_o  = '0;
        bus_err_o   = 1'b0;

        // Data has priority on the shared request fields.
        if (dm_req_i) begin
            mem_we_o    = dm_we_i;
            mem_be_o    = dm_be_i;
            mem_addr_o  = dm_addr_i;
            mem_wdata_o = dm_wdata_i;
        end else begin
            mem_we_o    = 1'b0;
            mem_be_o    = 4'hF;
            mem_addr_o  = if_addr_i;
            mem_wdata_o = '0;
        end

        case (state_q)
            S_IDLE: begin
                // A fetch being flushed is not worth starting.
                req       = dm_req_i | (if_req_i & ~flush_i);
                mem_req_o = req;
                if (req && mem_gnt_i) begin
                    state_d = dm_req_i ? S_DWAIT : S_IWAIT;
                    cnt_d   = '0;
                end
            end
            S_DWAIT: begin
                // Stores also complete on rvalid; flush never touches data.
                if (mem_rvalid_i) begin
                    dm_valid_o = 1'b1;
                    dm_rdata_o = mem_rdata_i;
                    state_d    = S_IDLE;
                end else if (timeout) begin
                    bus_err_o  = 1'b1;
                    dm_valid_o = 1'b1;
                    state_d    = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_IWAIT: begin
                if (mem_rvalid_i) begin
                    if (!flush_i) begin
                        if_valid_o = 1'b1;
                        if_rdata_o = mem_rdata_i;
                    end
                    state_d = S_IDLE;
                end else if (timeout) begin
                    bus_err_o  = 1'b1;
                    if_valid_o = ~flush_i;
                    state_d    = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                    // The fetch is still in flight: wait for it and throw it away.
                    if (flush_i) begin
                        state_d = S_IDROP;
                    end
                end
            end
            default: begin
                // S_IDROP: swallow the stale fetch response.
                if (mem_rvalid_i) begin
                    state_d = S_IDLE;
                end else if (timeout) begin
                    bus_err_o = 1'b1;
                    state_d   = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
        endcase

        stall_mw_o = dm_req_i & ~dm_valid_o;
        stall_fd_o = if_req_i & ~if_valid_o & ~flush_i;

        // Everything is quiet while reset is held.
        if (rst_i) begin
            mem_req_o   = 1'b0;
            mem_we_o    = 1'b0;
            mem_be_o    = '0;
            mem_addr_o  = '0;
            mem_wdata_o = '0;
            if_valid_o  = 1'b0;
            if_rdata_o  = '0;
            dm_valid_o  = 1'b0;
            dm_rdata_o  = '0;
            stall_fd_o  = 1'b0;
            stall_mw_o  = 1'b0;
            bus_err_o   = 1'b0;
        end
    end

    // State and wait-counter registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
        if (rst_i) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a per-cycle vector table with
// hand-computed outputs, followed by two hand-written multi-cycle sequences.
module tb_mem_port_arbiter;

    logic        clk_i = 1'b0;
    logic        rst_i, if_req_i, dm_req_i, dm_we_i, flush_i, mem_gnt_i, mem_rvalid_i;
    logic [31:0] if_addr_i, dm_addr_i, dm_wdata_i, mem_rdata_i;
    logic [3:0]  dm_be_i;
    logic [31:0] if_rdata_o, dm_rdata_o, mem_addr_o, mem_wdata_o;
    logic        if_valid_o, dm_valid_o, mem_req_o, mem_we_o, stall_fd_o, stall_mw_o, bus_err_o;
    logic [3:0]  mem_be_o;

    int checks = 0;
    int errors = 0;

    mem_port_arbiter #(.TO_CYCLES(4)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_rdata_o(if_rdata_o), .if_valid_o(if_valid_o),
        .dm_req_i(dm_req_i), .dm_we_i(dm_we_i), .dm_be_i(dm_be_i), .dm_addr_i(dm_addr_i),
        .dm_wdata_i(dm_wdata_i), .dm_rdata_o(dm_rdata_o), .dm_valid_o(dm_valid_o),
        .flush_i(flush_i),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i),
        .mem_rdata_i(mem_rdata_i),
        .stall_fd_o(stall_fd_o), .stall_mw_o(stall_mw_o), .bus_err_o(bus_err_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        string       name;
        logic        rst, ifr;
        logic [31:0] ifa;
        logic        dmr, we;
        logic [3:0]  be;
        logic [31:0] dma, wd;
        logic        fl, gnt, rv;
        logic [31:0] rd;
        logic        e_req, e_we;
        logic [3:0]  e_be;
        logic [31:0] e_addr, e_wd;
        logic        e_ifv;
        logic [31:0] e_ifd;
        logic        e_dmv;
        logic [31:0] e_dmd;
        logic        e_sfd, e_smw, e_err;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(input string n, input logic rst, input logic ifr, input logic [31:0] ifa,
                       input logic dmr, input logic we, input logic [3:0] be, input logic [31:0] dma,
                       input logic [31:0] wd, input logic fl, input logic gnt, input logic rv,
                       input logic [31:0] rd,
                       input logic e_req, input logic e_we, input logic [3:0] e_be,
                       input logic [31:0] e_addr, input logic [31:0] e_wd,
                       input logic e_ifv, input logic [31:0] e_ifd,
                       input logic e_dmv, input logic [31:0] e_dmd,
                       input logic e_sfd, input logic e_smw, input logic e_err);
        vec_t r;
        r.name = n; r.rst = rst; r.ifr = ifr; r.ifa = ifa; r.dmr = dmr; r.we = we; r.be = be;
        r.dma = dma; r.wd = wd; r.fl = fl; r.gnt = gnt; r.rv = rv; r.rd = rd;
        r.e_req = e_req; r.e_we = e_we; r.e_be = e_be; r.e_addr = e_addr; r.e_wd = e_wd;
        r.e_ifv = e_ifv; r.e_ifd = e_ifd; r.e_dmv = e_dmv; r.e_dmd = e_dmd;
        r.e_sfd = e_sfd; r.e_smw = e_smw; r.e_err = e_err;
        vecs.push_back(r);
    endtask

    task automatic drive(input vec_t r);
        rst_i = r.rst; if_req_i = r.ifr; if_addr_i = r.ifa; dm_req_i = r.dmr; dm_we_i = r.we;
        dm_be_i = r.be; dm_addr_i = r.dma; dm_wdata_i = r.wd; flush_i = r.fl;
        mem_gnt_i = r.gnt; mem_rvalid_i = r.rv; mem_rdata_i = r.rd;
    endtask

    task automatic check_row(input vec_t r);
        check({r.name, ".mem_req"},   32'(mem_req_o),  32'(r.e_req));
        check({r.name, ".mem_we"},    32'(mem_we_o),   32'(r.e_we));
        check({r.name, ".mem_be"},    32'(mem_be_o),   32'(r.e_be));
        check({r.name, ".mem_addr"},  mem_addr_o,      r.e_addr);
        check({r.name, ".mem_wdata"}, mem_wdata_o,     r.e_wd);
        check({r.name, ".if_valid"},  32'(if_valid_o), 32'(r.e_ifv));
        check({r.name, ".if_rdata"},  if_rdata_o,      r.e_ifd);
        check({r.name, ".dm_valid"},  32'(dm_valid_o), 32'(r.e_dmv));
        check({r.name, ".dm_rdata"},  dm_rdata_o,      r.e_dmd);
        check({r.name, ".stall_fd"},  32'(stall_fd_o), 32'(r.e_sfd));
        check({r.name, ".stall_mw"},  32'(stall_mw_o), 32'(r.e_smw));
        check({r.name, ".bus_err"},   32'(bus_err_o),  32'(r.e_err));
    endtask

    // Drive a quiet IDLE-style input set with a fetch request on the given address.
    task automatic set_fetch(input logic ifr, input logic [31:0] ifa, input logic fl,
                             input logic gnt, input logic rv, input logic [31:0] rd);
        rst_i = 1'b0; if_req_i = ifr; if_addr_i = ifa; dm_req_i = 1'b0; dm_we_i = 1'b0;
        dm_be_i = 4'h0; dm_addr_i = '0; dm_wdata_i = '0; flush_i = fl;
        mem_gnt_i = gnt; mem_rvalid_i = rv; mem_rdata_i = rd;
    endtask

    initial begin
        bit err_seen;
        int err_cycle;

        // Columns: name rst | ifr ifa | dmr we be dma wd | fl gnt rv rd ||
        //          req we be addr wdata | ifv ifd | dmv dmd | sfd smw err
        add("rst0", 1, 1, 32'h40, 1, 1, 4'h3, 32'h100, 32'hFFFF, 0, 1, 1, 32'h99,  0, 0, 4'h0, 0, 0,  0, 0, 0, 0,  0, 0, 0);
        add("rst1", 1, 1, 32'h40, 1, 1, 4'h3, 32'h100, 32'hFFFF, 0, 1, 1, 32'h99,  0, 0, 4'h0, 0, 0,  0, 0, 0, 0,  0, 0, 0);
        // Fetch, immediate grant, response two cycles later.
        add("f_acc",  0, 1, 32'h40, 0, 0, 0, 0, 0, 0, 1, 0, 0,            1, 0, 4'hF, 32'h40, 0,  0, 0, 0, 0,  1, 0, 0);
        add("f_w1",   0, 1, 32'h40, 0, 0, 0, 0, 0, 0, 0, 0, 0,            0, 0, 4'hF, 32'h40, 0,  0, 0, 0, 0,  1, 0, 0);
        add("f_done", 0, 1, 32'h40, 0, 0, 0, 0, 0, 0, 0, 1, 32'h13,       0, 0, 4'hF, 32'h40, 0,  1, 32'h13, 0, 0,  0, 0, 0);
        add("idl_rv", 0, 0, 32'h40, 0, 0, 0, 0, 0, 0, 0, 1, 32'hDEAD,     0, 0, 4'hF, 32'h40, 0,  0, 0, 0, 0,  0, 0, 0);
        // Simultaneous data and fetch: data goes first.
        add("b_acc",  0, 1, 32'h44, 1, 0, 4'hF, 32'h100, 0, 0, 1, 0, 0,  1, 0, 4'hF, 32'h100, 0, 0, 0, 0, 0,  1, 1, 0);
        add("b_done", 0, 1, 32'h44, 1, 0, 4'hF, 32'h100, 0, 0, 0, 1, 32'hCAFE0001, 0, 0, 4'hF, 32'h100, 0, 0, 0, 1, 32'hCAFE0001, 1, 0, 0);
        add("b_facc", 0, 1, 32'h44, 0, 0, 0, 0, 0, 0, 1, 0, 0,            1, 0, 4'hF, 32'h44, 0,  0, 0, 0, 0,  1, 0, 0);
        add("b_fdn",  0, 1, 32'h44, 0, 0, 0, 0, 0, 0, 0, 1, 32'h93,       0, 0, 4'hF, 32'h44, 0,  1, 32'h93, 0, 0,  0, 0, 0);
        // Store held off by three cycles without grant.
        add("s_ng1",  0, 1, 32'h48, 1, 1, 4'h3, 32'h200, 32'h12345678, 0, 0, 0, 0,  1, 1, 4'h3, 32'h200, 32'h12345678, 0, 0, 0, 0, 1, 1, 0);
        add("s_ng2",  0, 1, 32'h48, 1, 1, 4'h3, 32'h200, 32'h12345678, 0, 0, 0, 0,  1, 1, 4'h3, 32'h200, 32'h12345678, 0, 0, 0, 0, 1, 1, 0);
        add("s_ng3",  0, 1, 32'h48, 1, 1, 4'h3, 32'h200, 32'h12345678, 0, 0, 0, 0,  1, 1, 4'h3, 32'h200, 32'h12345678, 0, 0, 0, 0, 1, 1, 0);
        add("s_acc",  0, 1, 32'h48, 1, 1, 4'h3, 32'h200, 32'h12345678, 0, 1, 0, 0,  1, 1, 4'h3, 32'h200, 32'h12345678, 0, 0, 0, 0, 1, 1, 0);
        add("s_done", 0, 0, 32'h48, 1, 1, 4'h3, 32'h200, 32'h12345678, 0, 0, 1, 32'hFFFFFFFF, 0, 1, 4'h3, 32'h200, 32'h12345678, 0, 0, 1, 32'hFFFFFFFF, 0, 0, 0);
        // Flush while a fetch is in flight.
        add("fl_acc", 0, 1, 32'h80, 0, 0, 0, 0, 0, 0, 1, 0, 0,            1, 0, 4'hF, 32'h80, 0,  0, 0, 0, 0,  1, 0, 0);
        add("fl_fl",  0, 1, 32'h80, 0, 0, 0, 0, 0, 1, 0, 0, 0,            0, 0, 4'hF, 32'h80, 0,  0, 0, 0, 0,  0, 0, 0);
        add("fl_drp", 0, 1, 32'h84, 0, 0, 0, 0, 0, 0, 1, 0, 0,            0, 0, 4'hF, 32'h84, 0,  0, 0, 0, 0,  1, 0, 0);
        add("fl_rv",  0, 1, 32'h84, 0, 0, 0, 0, 0, 0, 0, 1, 32'hBAD,      0, 0, 4'hF, 32'h84, 0,  0, 0, 0, 0,  1, 0, 0);
        add("fl_idl", 0, 1, 32'h84, 0, 0, 0, 0, 0, 0, 0, 0, 0,            1, 0, 4'hF, 32'h84, 0,  0, 0, 0, 0,  1, 0, 0);
        add("fl_msk", 0, 1, 32'h84, 0, 0, 0, 0, 0, 1, 1, 0, 0,            0, 0, 4'hF, 32'h84, 0,  0, 0, 0, 0,  0, 0, 0);
        // Data timeout after four cycles (flush in D_WAIT is ignored).
        add("to_acc", 0, 0, 0, 1, 0, 4'hF, 32'h300, 0, 0, 1, 0, 0,        1, 0, 4'hF, 32'h300, 0, 0, 0, 0, 0,  0, 1, 0);
        add("to_w1",  0, 0, 0, 1, 0, 4'hF, 32'h300, 0, 1, 0, 0, 0,        0, 0, 4'hF, 32'h300, 0, 0, 0, 0, 0,  0, 1, 0);
        add("to_w2",  0, 0, 0, 1, 0, 4'hF, 32'h300, 0, 0, 0, 0, 0,        0, 0, 4'hF, 32'h300, 0, 0, 0, 0, 0,  0, 1, 0);
        add("to_w3",  0, 0, 0, 1, 0, 4'hF, 32'h300, 0, 0, 0, 0, 0,        0, 0, 4'hF, 32'h300, 0, 0, 0, 0, 0,  0, 1, 0);
        add("to_err", 0, 0, 0, 1, 0, 4'hF, 32'h300, 0, 0, 0, 0, 0,        0, 0, 4'hF, 32'h300, 0, 0, 0, 1, 0,  0, 0, 1);
        add("to_lat", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h55,           0, 0, 4'hF, 0, 0,       0, 0, 0, 0,  0, 0, 0);
        // Fetch timeout.
        add("ft_acc", 0, 1, 32'h90, 0, 0, 0, 0, 0, 0, 1, 0, 0,            1, 0, 4'hF, 32'h90, 0,  0, 0, 0, 0,  1, 0, 0);
        add("ft_w1",  0, 1, 32'h90, 0, 0, 0, 0, 0, 0, 0, 0, 0,            0, 0, 4'hF, 32'h90, 0,  0, 0, 0, 0,  1, 0, 0);
        add("ft_w2",  0, 1, 32'h90, 0, 0, 0, 0, 0, 0, 0, 0, 0,            0, 0, 4'hF, 32'h90, 0,  0, 0, 0, 0,  1, 0, 0);
        add("ft_w3",  0, 1, 32'h90, 0, 0, 0, 0, 0, 0, 0, 0, 0,            0, 0, 4'hF, 32'h90, 0,  0, 0, 0, 0,  1, 0, 0);
        add("ft_err", 0, 1, 32'h90, 0, 0, 0, 0, 0, 0, 0, 0, 0,            0, 0, 4'hF, 32'h90, 0,  1, 0, 0, 0,  0, 0, 1);
        // Reset in D_WAIT abandons the load; the stale response is ignored.
        add("rs_acc", 0, 0, 0, 1, 0, 4'hF, 32'h400, 0, 0, 1, 0, 0,        1, 0, 4'hF, 32'h400, 0, 0, 0, 0, 0,  0, 1, 0);
        add("rs_rst", 1, 1, 32'h50, 1, 0, 4'hF, 32'h400, 0, 0, 1, 0, 0,   0, 0, 4'h0, 0, 0,       0, 0, 0, 0,  0, 0, 0);
        add("rs_stl", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h77,           0, 0, 4'hF, 0, 0,       0, 0, 0, 0,  0, 0, 0);

        foreach (vecs[i]) begin
            @(negedge clk_i);
            drive(vecs[i]);
            #2;
            check_row(vecs[i]);
        end

        // Flush and rvalid together in I_WAIT: response dropped, back to IDLE at once.
        @(negedge clk_i); set_fetch(1, 32'hA0, 0, 1, 0, 0); #2;
        check("fr_acc.mem_req", 32'(mem_req_o), 32'd1);
        @(negedge clk_i); set_fetch(1, 32'hA0, 1, 0, 1, 32'h1234); #2;
        check("fr_both.if_valid", 32'(if_valid_o), 32'd0);
        check("fr_both.if_rdata", if_rdata_o, 32'h0);
        check("fr_both.mem_req", 32'(mem_req_o), 32'd0);
        @(negedge clk_i); set_fetch(1, 32'hA4, 0, 0, 0, 0); #2;
        check("fr_idle.mem_req", 32'(mem_req_o), 32'd1);

        // Flushed fetch that never answers: bus error from I_DROP, no fetch pulse.
        @(negedge clk_i); set_fetch(1, 32'hB0, 0, 1, 0, 0); #2;
        check("dt_acc.mem_req", 32'(mem_req_o), 32'd1);
        err_seen = 1'b0;
        err_cycle = 0;
        for (int c = 1; c <= 8 && !err_seen; c++) begin
            @(negedge clk_i); set_fetch(1, 32'hB0, (c == 1), 0, 0, 0); #2;
            check($sformatf("dt_c%0d.if_valid", c), 32'(if_valid_o), 32'd0);
            if (bus_err_o === 1'b1) begin
                err_seen = 1'b1;
                err_cycle = c;
            end
        end
        if (!err_seen) begin
            errors++;
            $display("FAIL dt_timeout: no bus_err within 8 cycles, expected one at cycle 4");
        end
        check("dt_timeout.cycle", 32'(err_cycle), 32'd4);
        @(negedge clk_i); set_fetch(1, 32'hB4, 0, 0, 0, 0); #2;
        check("dt_idle.mem_req", 32'(mem_req_o), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
